// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shift unit applying one 1-bit SLL/SRA/SRL/ROR stage per clock.
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  output logic             ready,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, res_q, res_d, step;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  always_comb
    step = op_q == 2'b00 ? {acc_q[WIDTH-2:0], 1'b0} :
           op_q == 2'b01 ? {acc_q[WIDTH-1], acc_q[WIDTH-1:1]} :
           op_q == 2'b10 ? {1'b0, acc_q[WIDTH-1:1]} :
                           {acc_q[0], acc_q[WIDTH-1:1]};
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      IDLE: if (start) begin
        acc_d   = data_in;
        op_d    = op;
        cnt_d   = shamt;
        state_d = shamt != '0 ? SHIFT : DONE;
      end
      SHIFT: begin
        acc_d   = step;
        cnt_d   = cnt_q - SHW'(1);
        state_d = cnt_q == SHW'(1) ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
    // result is captured only on the transition into DONE so it holds across idle cycles
    res_d = (state_d == DONE && state_q != DONE) ? acc_d : res_q;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  assign ready        = state_q == IDLE;
  assign busy         = ~ready;
  assign result_valid = state_q == DONE;
  assign result       = res_q;
endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: directed self-checking bench for iter_shifter.
module tb_iter_shifter;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt = '0;
  logic        ready, busy, result_valid;
  logic [31:0] result;
  int n_cmp = 0;
  int n_err = 0;

  iter_shifter dut (
    .clock(clock), .resetn(resetn), .start(start), .op(op), .data_in(data_in),
    .shamt(shamt), .ready(ready), .busy(busy), .result_valid(result_valid), .result(result)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                        input logic [31:0] exp, input string tag);
    int lat;
    chk({tag, " ready"}, 32'(ready), 1);
    start = 1'b1; op = o; data_in = d; shamt = s;
    tick();
    start = 1'b0;
    chk({tag, " busy"}, 32'(busy), 1);
    lat = 0;
    while (!result_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, 32'(s));
    chk({tag, " result"}, result, exp);
    chk({tag, " ready in done"}, 32'(ready), 0);
    tick();
    chk({tag, " ready back"}, 32'(ready), 1);
    chk({tag, " valid one cycle"}, 32'(result_valid), 0);
    chk({tag, " held"}, result, exp);
  endtask

  initial begin
    int cnt;
    #1;
    chk("rst ready", 32'(ready), 1);
    chk("rst busy", 32'(busy), 0);
    chk("rst valid", 32'(result_valid), 0);
    chk("rst result", result, 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    run_op(2'b01, 32'h8000_0010, 5'd4, 32'hF800_0001, "sra4");
    run_op(2'b10, 32'h8000_0010, 5'd4, 32'h0800_0001, "srl4");
    run_op(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, "sll31");
    run_op(2'b01, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, "sra0");

    // ROR with start/data disturbance while busy
    chk("ror ready", 32'(ready), 1);
    start = 1'b1; op = 2'b11; data_in = 32'h0000_0001; shamt = 5'd1;
    tick();
    data_in = 32'hFFFF_FFFF; op = 2'b00; shamt = 5'd3;
    chk("ror busy", 32'(busy), 1);
    tick();
    chk("ror valid", 32'(result_valid), 1);
    chk("ror result", result, 32'h8000_0000);
    tick();
    start = 1'b0;
    chk("ror ready back", 32'(ready), 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (result_valid) cnt++;
    end
    chk("ror no extra valid", cnt, 0);
    chk("ror result kept", result, 32'h8000_0000);

    // start held high: a completion every 4 cycles
    start = 1'b1; op = 2'b00; data_in = 32'h0000_0001; shamt = 5'd2;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("b2b valid c%0d", i), 32'(result_valid), (i % 4 == 2) ? 1 : 0);
      chk($sformatf("b2b result c%0d", i), result, i < 2 ? 32'h8000_0000 : 32'h4);
    end
    start = 1'b0;
    tick();
    chk("b2b idle", 32'(ready), 1);

    // asynchronous reset in the middle of SHIFT
    start = 1'b1; op = 2'b01; data_in = 32'hFFFF_0000; shamt = 5'd10;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("mid busy", 32'(busy), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid rst ready", 32'(ready), 1);
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst valid", 32'(result_valid), 0);
    chk("mid rst result", result, 0);
    tick();
    resetn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (result_valid) cnt++;
    end
    chk("post rst no valid", cnt, 0);
    chk("post rst result", result, 0);
    run_op(2'b01, 32'hFFFF_0000, 5'd10, 32'hFFFF_FFC0, "sra10");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
